// File: rtl/led_panel_rx_if.sv
// Bundle of the LED panel shift port, frame-buffer readout port and row
// status outputs. The master modport belongs to whoever drives the panel
// and reads pixels back; the slave modport belongs to led_panel_rx.
// Optional build macro: LED_PANEL_RX_ERRCNT_EN adds the err_cnt status output.
interface led_panel_rx_if #(
  parameter int WIDTH = 32
);
  localparam int COLW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Panel side (asynchronous to the system clock)
  logic            rgb_clk;
  logic [2:0]      rgb0;
  logic [2:0]      rgb1;
  logic            rgb_a;
  logic            rgb_b;
  logic            rgb_c;
  logic            rgb_stb;

  // Frame-buffer readout
  logic [3:0]      rd_row;
  logic [COLW-1:0] rd_col;
  logic [2:0]      rd_pix;

  // Row status
  logic            row_done;
  logic            frame_done;
  logic [2:0]      last_row;
  logic            short_row;
  logic            long_row;
`ifdef LED_PANEL_RX_ERRCNT_EN
  logic [7:0]      err_cnt;
`endif

`ifdef LED_PANEL_RX_ERRCNT_EN
  modport master (
    output rgb_clk, rgb0, rgb1, rgb_a, rgb_b, rgb_c, rgb_stb, rd_row, rd_col,
    input  rd_pix, row_done, frame_done, last_row, short_row, long_row, err_cnt
  );
  modport slave (
    input  rgb_clk, rgb0, rgb1, rgb_a, rgb_b, rgb_c, rgb_stb, rd_row, rd_col,
    output rd_pix, row_done, frame_done, last_row, short_row, long_row, err_cnt
  );
`else
  modport master (
    output rgb_clk, rgb0, rgb1, rgb_a, rgb_b, rgb_c, rgb_stb, rd_row, rd_col,
    input  rd_pix, row_done, frame_done, last_row, short_row, long_row
  );
  modport slave (
    input  rgb_clk, rgb0, rgb1, rgb_a, rgb_b, rgb_c, rgb_stb, rd_row, rd_col,
    output rd_pix, row_done, frame_done, last_row, short_row, long_row
  );
`endif
endinterface

// File: rtl/led_panel_rx.sv
// LED panel receiver: captures a HUB75-style serial pixel stream (two
// half-panels shifted in parallel on rgb_clk, latched by rgb_stb) into a
// 16-row x WIDTH-column frame buffer that can be read back on clk.
// All panel inputs are resynchronised into the clk domain; rgb_clk and
// rgb_stb are edge-detected on their synchronised copies.
// Optional build macro: LED_PANEL_RX_ERRCNT_EN adds an 8-bit saturating
// count of latches whose shift count was short or long.
module led_panel_rx #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  led_panel_rx_if.slave bus
);

  localparam int COLW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW   = $clog2(WIDTH + 2);
  localparam int NSYN = 11;

  typedef logic [2:0] pix_t;

  // Synchronised bit positions inside the packed panel-input vector
  localparam int B_RGB0 = 0;
  localparam int B_RGB1 = 3;
  localparam int B_ABC  = 6;
  localparam int B_STB  = 9;
  localparam int B_CLK  = 10;

  logic [NSYN-1:0] in_raw;

  logic [NSYN-1:0] sync1_q, sync1_d;
  logic [NSYN-1:0] sync2_q, sync2_d;
  logic            pclk_q,  pclk_d;
  logic            pstb_q,  pstb_d;
  logic [1:0]      warm_q,  warm_d;

  pix_t [WIDTH-1:0] up_q, up_d;
  pix_t [WIDTH-1:0] lo_q, lo_d;
  pix_t [WIDTH-1:0] fb_q [16];
  pix_t [WIDTH-1:0] fb_d [16];

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic       row_done_q,   row_done_d;
  logic       frame_done_q, frame_done_d;
  logic [2:0] last_row_q,   last_row_d;
  logic       short_row_q,  short_row_d;
  logic       long_row_q,   long_row_d;
  pix_t       rd_pix_q,     rd_pix_d;
`ifdef LED_PANEL_RX_ERRCNT_EN
  logic [7:0] err_cnt_q,    err_cnt_d;
`endif

  logic       s_clk, s_stb;
  logic [2:0] s_abc;
  pix_t       s_rgb0, s_rgb1;
  logic       armed;
  logic       shift_evt, stb_evt;

  assign in_raw = {bus.rgb_clk, bus.rgb_stb,
                   bus.rgb_c, bus.rgb_b, bus.rgb_a,
                   bus.rgb1, bus.rgb0};

  assign s_rgb0 = sync2_q[B_RGB0 +: 3];
  assign s_rgb1 = sync2_q[B_RGB1 +: 3];
  assign s_abc  = sync2_q[B_ABC  +: 3];
  assign s_stb  = sync2_q[B_STB];
  assign s_clk  = sync2_q[B_CLK];

  // Edge detection is held off until sync1, sync2 and the previous-value
  // flops all carry sampled input rather than reset zeros, so a line that
  // is already high when reset releases is never mistaken for a rising edge.
  assign armed     = (warm_q == 2'd3);
  assign shift_evt = armed & s_clk & ~pclk_q;
  assign stb_evt   = armed & s_stb & ~pstb_q;

  // Next-state logic: synchronisers, shift path, row latch and readout
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so
    // no path leaves a value unassigned and no latch is inferred.
    sync1_d      = in_raw;
    sync2_d      = sync1_q;
    pclk_d       = s_clk;
    pstb_d       = s_stb;
    warm_d       = armed ? warm_q : warm_q + 2'd1;

    up_d         = up_q;
    lo_d         = lo_q;
    fb_d         = fb_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;

    row_done_d   = 1'b0;
    frame_done_d = 1'b0;
    last_row_d   = last_row_q;
    short_row_d  = short_row_q;
    long_row_d   = long_row_q;
`ifdef LED_PANEL_RX_ERRCNT_EN
    err_cnt_d    = err_cnt_q;
`endif

    // Shift first: new pixel enters at column WIDTH-1, older ones move down
    if (shift_evt) begin
      up_d = {s_rgb0, up_q[WIDTH-1:1]};
      lo_d = {s_rgb1, lo_q[WIDTH-1:1]};
      if (cnt_q == CW'(WIDTH)) begin
        ovf_d = 1'b1;
      end
      if (cnt_q != CW'(WIDTH + 1)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // Latch sees the post-shift registers and count from the block above
    if (stb_evt) begin
      fb_d[{1'b0, s_abc}] = up_d;
      fb_d[{1'b1, s_abc}] = lo_d;
      last_row_d   = s_abc;
      short_row_d  = (cnt_d < CW'(WIDTH));
      long_row_d   = ovf_d;
      row_done_d   = 1'b1;
      frame_done_d = (s_abc == 3'd7);
`ifdef LED_PANEL_RX_ERRCNT_EN
      if ((short_row_d || long_row_d) && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
`endif
      cnt_d = '0;
      ovf_d = 1'b0;
    end

    // Readout comes from the current buffer, so a same-cycle write is not seen
    if (int'(bus.rd_col) < WIDTH) begin
      rd_pix_d = fb_q[bus.rd_row][bus.rd_col];
    end else begin
      rd_pix_d = 3'b000;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      pclk_q       <= 1'b0;
      pstb_q       <= 1'b0;
      warm_q       <= '0;
      up_q         <= '0;
      lo_q         <= '0;
      // NOTE: the frame buffer is built from flops rather than a RAM macro
      // because reset must clear every row; a RAM would need a clear sweep.
      for (int i = 0; i < 16; i++) begin
        fb_q[i] <= '0;
      end
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      last_row_q   <= '0;
      short_row_q  <= 1'b0;
      long_row_q   <= 1'b0;
      rd_pix_q     <= '0;
`ifdef LED_PANEL_RX_ERRCNT_EN
      err_cnt_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // blocking here would let sync2 see this cycle's sync1 and collapse
      // the two-stage synchroniser into one.
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      pclk_q       <= pclk_d;
      pstb_q       <= pstb_d;
      warm_q       <= warm_d;
      up_q         <= up_d;
      lo_q         <= lo_d;
      fb_q         <= fb_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
      last_row_q   <= last_row_d;
      short_row_q  <= short_row_d;
      long_row_q   <= long_row_d;
      rd_pix_q     <= rd_pix_d;
`ifdef LED_PANEL_RX_ERRCNT_EN
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

  assign bus.rd_pix     = rd_pix_q;
  assign bus.row_done   = row_done_q;
  assign bus.frame_done = frame_done_q;
  assign bus.last_row   = last_row_q;
  assign bus.short_row  = short_row_q;
  assign bus.long_row   = long_row_q;
`ifdef LED_PANEL_RX_ERRCNT_EN
  assign bus.err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_led_panel_rx.sv
// Scoreboard bench for led_panel_rx: stimulus tasks push expected row
// status and read-back pixels into queues; a negedge monitor pops and
// compares whenever row_done pulses or a read result becomes valid.
module tb_led_panel_rx;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;

  led_panel_rx_if #(.WIDTH(WIDTH)) bus ();

  led_panel_rx #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] row;
    logic       frame;
    logic       short_r;
    logic       long_r;
  } row_exp_t;

  row_exp_t   row_q [$];
  logic [2:0] rd_q  [$];
  row_exp_t   mon_e;
  logic [2:0] mon_p;

  int n_cmp  = 0;
  int n_fail = 0;

  logic rd_req;
  logic rd_vld;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Read result is valid on the negedge after the posedge that registered it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_vld <= 1'b0;
    else        rd_vld <= rd_req;
  end

  // Monitor: compare DUT outputs against queued expectations
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.row_done) begin
        if (row_q.size() == 0) begin
          check("unexpected_row_done", row_q.size(), 1);
        end else begin
          mon_e = row_q.pop_front();
          check("last_row",   bus.last_row,   mon_e.row);
          check("frame_done", bus.frame_done, mon_e.frame);
          check("short_row",  bus.short_row,  mon_e.short_r);
          check("long_row",   bus.long_row,   mon_e.long_r);
        end
      end else if (bus.frame_done) begin
        check("stray_frame_done", bus.row_done, 1);
      end
      if (rd_vld) begin
        if (rd_q.size() == 0) begin
          check("unexpected_read", rd_q.size(), 1);
        end else begin
          mon_p = rd_q.pop_front();
          check("rd_pix", bus.rd_pix, mon_p);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_px(input logic [2:0] p0, input logic [2:0] p1);
    bus.rgb0 = p0;
    bus.rgb1 = p1;
    step(4);
    bus.rgb_clk = 1'b1;
    step(4);
    bus.rgb_clk = 1'b0;
    step(4);
  endtask

  task automatic set_abc(input logic [2:0] abc);
    bus.rgb_a = abc[0];
    bus.rgb_b = abc[1];
    bus.rgb_c = abc[2];
  endtask

  task automatic expect_row(input logic [2:0] r, input logic sh, input logic lg);
    row_exp_t e;
    e.row = r; e.frame = (r == 3'd7); e.short_r = sh; e.long_r = lg;
    row_q.push_back(e);
  endtask

  task automatic strobe(input logic [2:0] abc);
    set_abc(abc);
    step(4);
    bus.rgb_stb = 1'b1;
    step(4);
    bus.rgb_stb = 1'b0;
    step(4);
  endtask

  task automatic read_px(input logic [3:0] row, input logic [4:0] col, input logic [2:0] exp);
    bus.rd_row = row;
    bus.rd_col = col;
    rd_q.push_back(exp);
    rd_req = 1'b1;
    step(1);
    rd_req = 1'b0;
  endtask

  // Shift n pixels with rgb0 = (c+ofs)[2:0], rgb1 = its complement
  task automatic shift_n(input int n, input int ofs);
    logic [2:0] p;
    for (int c = 0; c < n; c++) begin
      p = 3'(c + ofs);
      shift_px(p, ~p);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] p;
    rst_n       = 1'b0;
    rd_req      = 1'b0;
    bus.rgb_clk = 1'b0;
    bus.rgb0    = '0;
    bus.rgb1    = '0;
    bus.rgb_a   = 1'b0;
    bus.rgb_b   = 1'b0;
    bus.rgb_c   = 1'b0;
    bus.rgb_stb = 1'b0;
    bus.rd_row  = '0;
    bus.rd_col  = '0;
    step(3);
    rst_n = 1'b1;
    step(2);

    // Reset state
    check("rst_row_done",   bus.row_done,   0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_last_row",   bus.last_row,   0);
    check("rst_short_row",  bus.short_row,  0);
    check("rst_long_row",   bus.long_row,   0);
    check("rst_rd_pix",     bus.rd_pix,     0);
`ifdef LED_PANEL_RX_ERRCNT_EN
    check("rst_err_cnt",    bus.err_cnt,    0);
`endif

    // Full row into address 3: column c holds c[2:0] upper, ~c[2:0] lower
    shift_n(32, 0);
    expect_row(3'd3, 1'b0, 1'b0);
    strobe(3'd3);
    read_px(4'd3,  5'd5,  3'b101);
    read_px(4'd11, 5'd5,  3'b010);
    read_px(4'd3,  5'd0,  3'b000);
    read_px(4'd3,  5'd31, 3'b111);
    read_px(4'd11, 5'd31, 3'b000);
    read_px(4'd0,  5'd5,  3'b000);

    // Rows 0..7 in order; only row 7 raises frame_done
    for (int r = 0; r < 8; r++) begin
      shift_n(32, r);
      expect_row(3'(r), 1'b0, 1'b0);
      strobe(3'(r));
    end
    check("frame_last_row", bus.last_row, 7);
    read_px(4'd5,  5'd1, 3'b110);   // (1+5) = 6
    read_px(4'd13, 5'd1, 3'b001);   // ~6
    read_px(4'd6,  5'd2, 3'b000);   // (2+6) & 7 = 0

    // Short row (30 shifts) then long row (34 shifts)
    shift_n(30, 0);
    expect_row(3'd1, 1'b1, 1'b0);
    strobe(3'd1);
    shift_n(34, 0);
    expect_row(3'd2, 1'b0, 1'b1);
    strobe(3'd2);
    read_px(4'd2,  5'd0,  3'b010);  // pixel index 2 reaches column 0
    read_px(4'd2,  5'd31, 3'b001);  // pixel index 33
    read_px(4'd10, 5'd0,  3'b101);
`ifdef LED_PANEL_RX_ERRCNT_EN
    check("err_cnt_after_bad_rows", bus.err_cnt, 2);
`endif

    // 32nd shift edge coincident with strobe edge: latch sees the last pixel
    shift_n(31, 0);
    p = 3'b001;
    bus.rgb0 = p;
    bus.rgb1 = ~p;
    set_abc(3'd4);
    expect_row(3'd4, 1'b0, 1'b0);
    step(4);
    bus.rgb_clk = 1'b1;
    bus.rgb_stb = 1'b1;
    step(4);
    bus.rgb_clk = 1'b0;
    bus.rgb_stb = 1'b0;
    step(4);
    read_px(4'd4,  5'd31, 3'b001);
    read_px(4'd4,  5'd30, 3'b110);
    read_px(4'd12, 5'd31, 3'b110);

    // Reset mid-row discards partial data and clears the buffer
    shift_n(10, 0);
    rst_n = 1'b0;
    step(2);
    check("midrst_last_row",  bus.last_row,  0);
    check("midrst_short_row", bus.short_row, 0);
    check("midrst_long_row",  bus.long_row,  0);
    rst_n = 1'b1;
    step(2);
    read_px(4'd4, 5'd31, 3'b000);
    shift_n(32, 0);
    expect_row(3'd5, 1'b0, 1'b0);
    strobe(3'd5);
    read_px(4'd5,  5'd9, 3'b001);
    read_px(4'd5,  5'd0, 3'b000);
    read_px(4'd13, 5'd9, 3'b110);
    read_px(4'd0,  5'd9, 3'b000);
    read_px(4'd7,  5'd9, 3'b000);
`ifdef LED_PANEL_RX_ERRCNT_EN
    check("err_cnt_after_reset", bus.err_cnt, 0);
`endif

    step(4);
    check("pending_row_expectations",  row_q.size(), 0);
    check("pending_read_expectations", rd_q.size(),  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/led_panel_rx.md
LED_PANEL_RX -- requirements
Module: led_panel_rx

Interface
REQ-001 Parameter WIDTH, default 32, meaning columns per row shifted before each strobe.
REQ-002 clk  input  1  system clock; all state is updated on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 rgb_clk  input  1  panel shift clock, asynchronous to clk.
REQ-005 rgb0  input  3  upper-half pixel {b,g,r}.
REQ-006 rgb1  input  3  lower-half pixel {b,g,r}.
REQ-007 rgb_a, rgb_b, rgb_c  input  1 each  row address bits 0,1,2.
REQ-008 rgb_stb  input  1  latch strobe, active-high.
REQ-009 rd_row  input  4  readout row; 0-7 upper half, 8-15 lower half.
REQ-010 rd_col  input  log2(WIDTH)  readout column.
REQ-011 rd_pix  output  3  pixel at {rd_row,rd_col}.
REQ-012 row_done  output  1  one-cycle pulse after each row latch.
REQ-013 frame_done  output  1  one-cycle pulse coincident with row_done when the latched row address is 7.
REQ-014 last_row  output  3  row address of the most recent latch.
REQ-015 short_row, long_row  output  1 each  shift-count status of the most recent latch.

Function
REQ-016 All panel inputs SHALL pass through 2-flop synchronizers; edges SHALL be detected on the synchronized copies (3 clk input-to-edge latency).
REQ-017 Each synchronized rgb_clk rising edge SHALL shift the synchronized rgb0/rgb1 into two WIDTH-entry shift registers, entering at column WIDTH-1 and moving toward column 0.
REQ-018 After exactly WIDTH shifts, the first pixel shifted SHALL sit at column 0 and the last at column WIDTH-1.
REQ-019 A shift counter SHALL increment per shift, saturating at WIDTH+1; a shift while the count is at WIDTH SHALL set an internal overflow bit.
REQ-020 A synchronized rgb_stb rising edge SHALL write the upper register to buffer row {0,abc} and the lower register to row {1,abc}, using abc sampled in the same cycle.
REQ-021 On latch: last_row<=abc; short_row<=(count<WIDTH); long_row<=overflow; counter and overflow cleared; shift registers retained.
REQ-022 row_done SHALL pulse on the clk cycle following the latch cycle; frame_done likewise when abc was 7.
REQ-023 Shift and strobe edges in the same cycle: the shift SHALL apply first and the latch SHALL capture the post-shift contents; the counter SHALL then be cleared, not set to 1.
REQ-024 rgb_stb held high SHALL cause exactly one latch; rgb_clk edges while strobe is high SHALL still shift.
REQ-025 rd_pix SHALL be registered, valid one clk after rd_row/rd_col are applied; a read of a row being written in the same cycle SHALL return the old data.
REQ-026 An rd_col value >= WIDTH SHALL return 3'b000.

Reset
REQ-027 rst_n low SHALL clear synchronizers, shift registers, counter, overflow, frame buffer and all outputs to 0; assertion mid-row SHALL discard partial data with no row_done.
REQ-028 After deassertion, the first edge detection SHALL require a real 0->1 transition (no spurious edge from reset values).

Configuration
REQ-029 Macro LED_PANEL_RX_ERRCNT_EN defined: adds output err_cnt (8 bits, reset 0), incremented on each latch with short_row or long_row set, saturating at 255; macro undefined: no port and no logic.

Verification
REQ-030 32 shifts of rgb0=col[2:0], rgb1=~col[2:0], strobe, abc=3 -> row_done one cycle later; rd_row 3 col 5 reads 3'b101 next cycle; rd_row 11 col 5 reads 3'b010.
REQ-031 Rows 0-7 in sequence -> frame_done only with the row-7 row_done; last_row=7.
REQ-032 30 shifts then strobe -> short_row=1, long_row=0; 34 shifts then strobe -> long_row=1; with macro, err_cnt=2.
REQ-033 Strobe edge coincident with the 32nd shift edge -> latched row includes the 32nd pixel, short_row=0.
REQ-034 rst_n asserted after 10 shifts, then 32 shifts and strobe -> short_row=0, no row_done before that strobe; unwritten rows read 0.
